// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter / fetch sequencer.
package pc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } pc_state_t;

    localparam int PC_W_DEFAULT = 12;

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Program counter and run/idle/done fetch sequencer for the 8-bit core.
// Optional single-entry call/return link register enabled by defining PC_LINK_EN.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int unsigned  D      = PC_W_DEFAULT,
    parameter logic [D-1:0] PC_RST = '0
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Stall,
    input  logic         BranchEn,
    input  logic         AbsJump,
    input  logic [D-1:0] Target,
    input  logic         Halt,
`ifdef PC_LINK_EN
    input  logic         Call,
    input  logic         Ret,
`endif
    output logic [D-1:0] PC,
    output logic         Running,
    output logic         Done
);

    localparam logic [D-1:0] PC_ONE = {{(D-1){1'b0}}, 1'b1};

    pc_state_t    r_state;
    pc_state_t    w_stateNext;
    logic [D-1:0] r_pc;
    logic [D-1:0] w_pcNext;
`ifdef PC_LINK_EN
    logic [D-1:0] r_link;
    logic [D-1:0] w_linkNext;
`endif

    // Next-state / next-PC selection; relative branches wrap by dropping the carry.
    always_comb begin
        w_stateNext = r_state;
        w_pcNext    = r_pc;
`ifdef PC_LINK_EN
        w_linkNext  = r_link;
`endif
        case (r_state)
            IDLE, DONE: begin
                if (Start) begin
                    w_stateNext = RUN;
                    w_pcNext    = PC_RST;
                end
            end
            RUN: begin
                if (Halt) begin
                    w_stateNext = DONE;
                end else if (Stall) begin
                    w_pcNext = r_pc;
                end
`ifdef PC_LINK_EN
                else if (Call) begin
                    w_linkNext = r_pc + PC_ONE;
                    w_pcNext   = Target;
                end else if (Ret) begin
                    w_pcNext = r_link;
                end
`endif
                else if (BranchEn) begin
                    w_pcNext = AbsJump ? Target : (r_pc + Target);
                end else begin
                    w_pcNext = r_pc + PC_ONE;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_pcNext    = PC_RST;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_pc    <= PC_RST;
`ifdef PC_LINK_EN
            r_link  <= '0;
`endif
        end else begin
            r_state <= w_stateNext;
            r_pc    <= w_pcNext;
`ifdef PC_LINK_EN
            r_link  <= w_linkNext;
`endif
        end
    end

    assign PC      = r_pc;
    assign Running = (r_state == RUN);
    assign Done    = (r_state == DONE);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model. Define PC_LINK_EN to exercise Call/Ret.
module tb_pc_fetch_ctrl;

   localparam int D   = 12;
   localparam int MOD = 1 << D;
`ifdef PC_LINK_EN
   localparam bit LINK = 1'b1;
`else
   localparam bit LINK = 1'b0;
`endif

   logic         Clk = 1'b0;
   logic         Reset;
   logic         Start;
   logic         Stall;
   logic         BranchEn;
   logic         AbsJump;
   logic [D-1:0] Target;
   logic         Halt;
   logic         tbCall;
   logic         tbRet;
   logic [D-1:0] PC;
   logic         Running;
   logic         Done;

   int nChecks = 0;
   int nPassed = 0;

   // Reference model state: plain integers and flags
   int mPc      = 0;
   int mLink    = 0;
   bit mRunning = 1'b0;
   bit mDone    = 1'b0;

   pc_fetch_ctrl #(.D(D), .PC_RST('0)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Start    (Start),
      .Stall    (Stall),
      .BranchEn (BranchEn),
      .AbsJump  (AbsJump),
      .Target   (Target),
      .Halt     (Halt),
`ifdef PC_LINK_EN
      .Call     (tbCall),
      .Ret      (tbRet),
`endif
      .PC       (PC),
      .Running  (Running),
      .Done     (Done)
   );

   always #5 Clk = ~Clk;

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string tag, input int observed, input int expected);
      nChecks++;
      if (observed == expected) nPassed++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
   endtask

   // Drives all control inputs at once
   task automatic applyStimulus(input bit st, input bit sl, input bit br, input bit ab,
                                input bit hl, input int tg, input bit cl, input bit rt);
      Start    = st;
      Stall    = sl;
      BranchEn = br;
      AbsJump  = ab;
      Halt     = hl;
      Target   = tg[D-1:0];
      tbCall   = cl;
      tbRet    = rt;
   endtask

   // Reference model of one rising edge, written from the fetch rules
   task automatic modelEdge();
      if (Reset) begin
         mPc = 0; mLink = 0; mRunning = 1'b0; mDone = 1'b0;
      end else if (!mRunning) begin
         if (Start) begin
            mPc = 0; mRunning = 1'b1; mDone = 1'b0;
         end
      end else if (Halt) begin
         mRunning = 1'b0; mDone = 1'b1;
      end else if (Stall) begin
         mPc = mPc;
      end else if (LINK && tbCall) begin
         mLink = (mPc + 1) % MOD;
         mPc   = int'(Target);
      end else if (LINK && tbRet) begin
         mPc = mLink;
      end else if (BranchEn) begin
         mPc = AbsJump ? int'(Target) : (mPc + int'(Target)) % MOD;
      end else begin
         mPc = (mPc + 1) % MOD;
      end
   endtask

   // Advances one clock, updates the model and compares all outputs
   task automatic step(input string tag);
      @(posedge Clk);
      #1;
      modelEdge();
      checkOutput({tag, ".pc"}, int'(PC), mPc);
      checkOutput({tag, ".run"}, int'(Running), int'(mRunning));
      checkOutput({tag, ".done"}, int'(Done), int'(mDone));
   endtask

   // Asserts reset between edges and checks it takes effect before the next edge
   task automatic asyncReset(input string tag, input int holdCycles);
      #2;
      Reset = 1'b1;
      #1;
      mPc = 0; mLink = 0; mRunning = 1'b0; mDone = 1'b0;
      checkOutput({tag, ".asyncPc"}, int'(PC), 0);
      checkOutput({tag, ".asyncRun"}, int'(Running), 0);
      checkOutput({tag, ".asyncDone"}, int'(Done), 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < holdCycles; i++) step({tag, ".held"});
      Reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Jumps to an absolute address from RUN
   task automatic jumpTo(input int addr);
      applyStimulus(0, 0, 1, 1, 0, addr, 0, 0);
      step("jump");
   endtask

   initial begin
      Reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      #12;
      checkOutput("reset.pc", int'(PC), 0);
      checkOutput("reset.run", int'(Running), 0);
      checkOutput("reset.done", int'(Done), 0);
      @(negedge Clk);
      Reset = 1'b0;

      // Start pulse then free-running increments
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      step("t1.start");
      checkOutput("t1.firstFetch", int'(PC), 0);
      checkOutput("t1.running", int'(Running), 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         step("t1.seq");
         checkOutput("t1.seqPc", int'(PC), i);
      end

      // Relative branch with negative offset, then increment wrap
      jumpTo(20);
      applyStimulus(0, 0, 1, 0, 0, 'hFFB, 0, 0);
      step("t2.rel");
      checkOutput("t2.relPc", int'(PC), 15);
      jumpTo(4);
      applyStimulus(0, 0, 1, 0, 0, 'hFFF, 0, 0);
      step("t2.relM1");
      checkOutput("t2.relM1Pc", int'(PC), 3);
      jumpTo('hFFF);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      step("t2.wrap");
      checkOutput("t2.wrapPc", int'(PC), 0);

      // Stall discards a branch; the re-presented branch is then taken
      jumpTo(1);
      applyStimulus(0, 1, 1, 1, 0, 39, 0, 0);
      step("t3.stall");
      checkOutput("t3.stallPc", int'(PC), 1);
      applyStimulus(0, 0, 1, 1, 0, 39, 0, 0);
      step("t3.abs");
      checkOutput("t3.absPc", int'(PC), 39);

      // Halt beats branch, PC frozen in DONE, Start restarts at 0
      jumpTo(7);
      applyStimulus(0, 0, 1, 1, 1, 55, 0, 0);
      step("t4.halt");
      checkOutput("t4.done", int'(Done), 1);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, $urandom_range(0, 1) == 1, 1, $urandom_range(0, 1) == 1, 1,
                       int'($urandom_range(0, MOD - 1)), 0, 0);
         step("t4.hold");
         checkOutput("t4.holdPc", int'(PC), 7);
      end
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      step("t4.restart");
      checkOutput("t4.restartPc", int'(PC), 0);
      checkOutput("t4.restartRun", int'(Running), 1);

      // Asynchronous reset mid-cycle while running
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      jumpTo(100);
      checkOutput("t5.pc100", int'(PC), 100);
      asyncReset("t5", 3);
      step("t5.afterRelease");
      checkOutput("t5.stillIdle", int'(Running), 0);

`ifdef PC_LINK_EN
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      step("t6.start");
      jumpTo(10);
      applyStimulus(0, 0, 1, 0, 0, 39, 1, 0);
      step("t6.call");
      checkOutput("t6.callPc", int'(PC), 39);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      step("t6.body");
      applyStimulus(0, 0, 1, 1, 0, 200, 0, 1);
      step("t6.ret");
      checkOutput("t6.retPc", int'(PC), 11);
      applyStimulus(0, 0, 0, 0, 0, 50, 1, 1);
      step("t6.callRet");
      checkOutput("t6.callRetPc", int'(PC), 50);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      step("t6.ret2");
      checkOutput("t6.ret2Pc", int'(PC), 12);
`endif

      // Randomized traffic against the model
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      step("rnd.start");
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            asyncReset("rnd.reset", 1);
         end else begin
            applyStimulus($urandom_range(0, 3) == 0,
                          $urandom_range(0, 4) == 0,
                          $urandom_range(0, 2) == 0,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 29) == 0,
                          int'($urandom_range(0, MOD - 1)),
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 9) == 0);
            step("rnd");
         end
      end

      $display("[TB] %0d/%0d checks passed", nPassed, nChecks);
      $finish;
   end

endmodule
